ramb4_s1_arb: RTL and testbench
===============================

RAMB4_S1_ARB -- requirements
Module: ramb4_s1_arb

Interface
REQ-001 Parameter CLR_VALUE, default 1'b0: bit written to every location by the clear engine.
REQ-002 Parameter FIRST_A, default 1: reset value of the round-robin pointer; 1 = requester A wins the first contention.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 REQ_A / REQ_B  input  1  access request; held with its fields until granted.
REQ-006 WE_A / WE_B  input  1  1 = write, 0 = read.
REQ-007 ADDR_A / ADDR_B  input  12  bit address, 0..4095.
REQ-008 DI_A / DI_B  input  1  write data.
REQ-009 GNT_A / GNT_B  output  1  combinational accept; the request completes in this cycle.
REQ-010 RVALID_A / RVALID_B  output  1  read data valid, one cycle after a granted read.
REQ-011 RDATA_A / RDATA_B  output  1  read data; equals RAM_DO while the matching RVALID is high, 0 otherwise.
REQ-012 CLR_START  input  1  one-cycle pulse that starts a full-array clear.
REQ-013 CLR_BUSY  output  1  high while the clear engine owns the RAM port.
REQ-014 CLR_DONE  output  1  one-cycle pulse after the last clear write.
REQ-015 RAM_EN, RAM_WE  output  1 each  RAM port enable and write enable.
REQ-016 RAM_ADDR  output  12  RAM address.
REQ-017 RAM_DI  output  1  RAM write data.
REQ-018 RAM_DO  input  1  registered RAM read data; valid the cycle after an enabled read edge.

Function
REQ-019 The block SHALL be a two-state FSM: SERVE and CLEAR.
REQ-020 In SERVE, with exactly one REQ high, that requester SHALL be granted in the same cycle.
REQ-021 In SERVE, with both REQs high, the requester not most recently granted SHALL be granted; the pointer SHALL update only on a grant.
REQ-022 At most one GNT SHALL be high per cycle; GNT SHALL never be high in CLEAR or without the matching REQ.
REQ-023 On a grant, RAM_EN=1 and RAM_WE/ADDR/DI SHALL equal the granted requester's fields in the same cycle; otherwise, outside CLEAR, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0.
REQ-024 A granted read SHALL raise the matching RVALID in exactly the next cycle, for one cycle; a granted write SHALL raise no RVALID.
REQ-025 Back-to-back grants SHALL be sustained: one access per cycle, no bubble.
REQ-026 A CLR_START in SERVE SHALL enter CLEAR on the next edge; any REQ in that same cycle SHALL still be served normally.
REQ-027 In CLEAR, a 12-bit counter SHALL start at 0 and drive RAM_EN=1, RAM_WE=1, RAM_ADDR=counter, RAM_DI=CLR_VALUE, incrementing each cycle.
REQ-028 After the write to address 4095 the FSM SHALL return to SERVE, and CLR_DONE SHALL pulse in the first SERVE cycle; a clear therefore takes exactly 4096 cycles.
REQ-029 CLR_BUSY SHALL equal (state==CLEAR).
REQ-030 A CLR_START during CLEAR SHALL be ignored, with no restart and no extra CLR_DONE.
REQ-031 A read granted in the last SERVE cycle before CLEAR SHALL still return its RVALID.

Reset
REQ-032 While RST_N=0, the FSM SHALL be in SERVE, the clear counter 0, and the round-robin pointer equal to FIRST_A.
REQ-033 While RST_N=0, all outputs SHALL be 0: GNT, RVALID, RDATA, CLR_BUSY, CLR_DONE and all RAM_* outputs.
REQ-034 A reset during CLEAR SHALL abort the clear without a CLR_DONE; pending read returns SHALL be discarded.

Structure
REQ-035 Package ramb4_s1_arb_pkg SHALL hold ADDR_W=12, DEPTH=4096 and the state enum (SERVE, CLEAR).
REQ-036 The two-way round-robin decision SHALL be sub-module ramb4_s1_rr2 (inputs: req[1:0], pointer; outputs: one-hot gnt).

Verification
REQ-037 Both REQs high for 4 cycles from reset with FIRST_A=1 -> GNT sequence A,B,A,B.
REQ-038 A writes DI=1 to ADDR 0x7FF, then B reads 0x7FF on the next cycle -> RVALID_B=1 and RDATA_B=1 two cycles after A's grant.
REQ-039 CLR_START with CLR_VALUE=0 after writing 1s to 0x000 and 0xFFF -> CLR_BUSY high for 4096 cycles, one CLR_DONE, and reads of both addresses return 0.
REQ-040 CLR_START pulsed again at clear cycle 100 -> total clear length still 4096 cycles, one CLR_DONE.
REQ-041 RST_N=0 at clear cycle 2000 -> all outputs 0, no CLR_DONE; after release, REQ_B alone is granted immediately.
REQ-042 REQ_A held during a clear -> no GNT_A until the first SERVE cycle, then GNT_A in that cycle.

Source files
------------

// File: rtl/ramb4_s1_arb_pkg.sv
// ==================================================================
// ramb4_s1_arb_pkg : shared widths, FSM state and RAM command type
// Revision: 1.0
// ==================================================================
`default_nettype none

package ramb4_s1_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    typedef enum logic [0:0] {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic              di;
    } ram_cmd_t;

endpackage

`default_nettype wire

// File: rtl/ramb4_s1_arb_if.sv
// ==================================================================
// ramb4_s1_arb_if : two requester ports (A/B) of the RAM arbiter
// Revision: 1.0
// ==================================================================
`default_nettype none

interface ramb4_s1_arb_if;
    import ramb4_s1_arb_pkg::*;

    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              di_a;
    logic              di_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic              rdata_a;
    logic              rdata_b;

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, di_a, di_b,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
    );

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, di_a, di_b,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b
    );

endinterface

`default_nettype wire

// File: rtl/ramb4_s1_rr2.sv
// ==================================================================
// ramb4_s1_rr2 : two-way round-robin pick, one-hot grant (bit0 = A)
// Revision: 1.0
// ==================================================================
`default_nettype none

module ramb4_s1_rr2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] gnt
);

    // pointer = 1 gives A priority on contention
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = pointer ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ramb4_s1_arb.sv
// ==================================================================
// ramb4_s1_arb : round-robin two-port arbiter with full-array clear
// Revision: 1.0
// ==================================================================
`default_nettype none

module ramb4_s1_arb
    import ramb4_s1_arb_pkg::*;
#(
    parameter logic CLR_VALUE = 1'b0,
    parameter bit   FIRST_A   = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    ramb4_s1_arb_if.slave          bus,
    input  wire logic              clr_start,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_di,
    input  wire logic              ram_do
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_ptr_a;
    logic              r_rvalid_a;
    logic              r_rvalid_b;
    logic              r_clr_done;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    ram_cmd_t          w_cmd;

    // Requests are masked while clearing and while reset is held low
    assign w_req = {bus.req_b, bus.req_a} & {2{(r_state == SERVE) & rst_n}};

    ramb4_s1_rr2 u_rr2 (
        .req     (w_req),
        .pointer (r_ptr_a),
        .gnt     (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SERVE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SERVE:   if (clr_start) w_state_next = CLEAR;
            CLEAR:   if (r_clr_cnt == c_last_addr) w_state_next = SERVE;
            default: w_state_next = SERVE;
        endcase
    end

    always_comb begin
        w_cmd = '0;
        case (r_state)
            CLEAR: begin
                w_cmd.en   = 1'b1;
                w_cmd.we   = 1'b1;
                w_cmd.addr = r_clr_cnt;
                w_cmd.di   = CLR_VALUE;
            end
            default: begin
                if (w_gnt[0]) begin
                    w_cmd.en   = 1'b1;
                    w_cmd.we   = bus.we_a;
                    w_cmd.addr = bus.addr_a;
                    w_cmd.di   = bus.di_a;
                end else if (w_gnt[1]) begin
                    w_cmd.en   = 1'b1;
                    w_cmd.we   = bus.we_b;
                    w_cmd.addr = bus.addr_b;
                    w_cmd.di   = bus.di_b;
                end
            end
        endcase
        ram_en       = w_cmd.en;
        ram_we       = w_cmd.we;
        ram_addr     = w_cmd.addr;
        ram_di       = w_cmd.di;
        bus.gnt_a    = w_gnt[0];
        bus.gnt_b    = w_gnt[1];
        bus.rvalid_a = r_rvalid_a;
        bus.rvalid_b = r_rvalid_b;
        bus.rdata_a  = r_rvalid_a & ram_do;
        bus.rdata_b  = r_rvalid_b & ram_do;
        clr_busy     = (r_state == CLEAR);
        clr_done     = r_clr_done;
    end

    // Read returns are tracked independently of the FSM so a read granted
    // in the clr_start cycle still completes during the first clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt  <= '0;
            r_ptr_a    <= FIRST_A;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_rvalid_a <= w_gnt[0] & ~bus.we_a;
            r_rvalid_b <= w_gnt[1] & ~bus.we_b;
            if (w_gnt[0]) begin
                r_ptr_a <= 1'b0;
            end else if (w_gnt[1]) begin
                r_ptr_a <= 1'b1;
            end
            r_clr_done <= (r_state == CLEAR) && (r_clr_cnt == c_last_addr);
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ramb4_s1_arb.sv
// ==================================================================
// tb_ramb4_s1_arb : randomized scoreboard bench with RAM and ref model
// Revision: 1.0
// ==================================================================
`default_nettype none

module tb_ramb4_s1_arb;
    import ramb4_s1_arb_pkg::*;

    localparam bit CLRV = 1'b0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr_start = 1'b0;
    logic              clr_busy;
    logic              clr_done;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_di;
    logic              ram_do = 1'b0;

    ramb4_s1_arb_if bus ();

    ramb4_s1_arb #(.CLR_VALUE(CLRV), .FIRST_A(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    always #5 clk = ~clk;

    // Registered-output single-port RAM seen by the arbiter
    bit ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_di;
            else        ram_do <= ram_mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit side; bit data; int cyc; } rd_t;
    rd_t sb[$];

    int   tests = 0;
    int   fails = 0;
    bit   ref_mem [DEPTH];
    bit   m_ptr_a = 1'b1;
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   m_cnt = 0;
    bit   done_a = 1'b0;
    bit   done_b = 1'b0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    logic [1:0] last_gnt = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: evaluated once per cycle on the falling edge
    task automatic check_cycle();
        bit ea, eb, g_we, g_di, nd;
        logic [ADDR_W-1:0] g_addr;
        logic [14:0] eport;
        if (!rst_n) begin
            chk("reset_outputs", 32'({bus.gnt_a, bus.gnt_b, bus.rvalid_a, bus.rvalid_b,
                 bus.rdata_a, bus.rdata_b, clr_busy, clr_done, ram_en, ram_we, ram_addr, ram_di}), 32'd0);
            m_busy = 1'b0; m_done = 1'b0; m_ptr_a = 1'b1; m_cnt = 0;
            done_a = 1'b0; done_b = 1'b0; last_gnt = 2'b00;
            sb.delete();
            return;
        end
        ea = !m_busy && bus.req_a && (!bus.req_b || m_ptr_a);
        eb = !m_busy && bus.req_b && (!bus.req_a || !m_ptr_a);
        chk("grant", 32'({bus.gnt_a, bus.gnt_b}), 32'({ea, eb}));
        last_gnt = {bus.gnt_a, bus.gnt_b};
        g_we = ea ? bus.we_a : bus.we_b;
        g_di = ea ? bus.di_a : bus.di_b;
        g_addr = ea ? bus.addr_a : bus.addr_b;
        if (m_busy)          eport = {1'b1, 1'b1, 12'(m_cnt), CLRV};
        else if (ea || eb)   eport = {1'b1, g_we, g_addr, g_di};
        else                 eport = 15'd0;
        chk("ram_port", 32'({ram_en, ram_we, ram_addr, ram_di}), 32'(eport));
        chk("clr_busy", 32'(clr_busy), 32'(m_busy));
        chk("clr_done", 32'(clr_done), 32'(m_done));
        busy_cnt += int'(clr_busy);
        done_cnt += int'(clr_done);
        if (ea || eb) begin
            if (!g_we) sb.push_back('{eb, ref_mem[g_addr], cyc});
            else       ref_mem[g_addr] = g_di;
            m_ptr_a = eb;
        end
        done_a = ea;
        done_b = eb;
        nd = m_busy && (m_cnt == DEPTH - 1);
        if (m_busy) begin
            ref_mem[m_cnt] = CLRV;
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            else                    m_cnt++;
        end else if (clr_start) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end
        m_done = nd;
    endtask

    always @(negedge clk) begin : monitor
        rd_t e;
        if (rst_n) begin
            if (!bus.rvalid_a) chk("rdata_a_idle", 32'(bus.rdata_a), 32'd0);
            if (!bus.rvalid_b) chk("rdata_b_idle", 32'(bus.rdata_b), 32'd0);
            if (bus.rvalid_a || bus.rvalid_b) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 32'({bus.rvalid_a, bus.rvalid_b}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_side", 32'({bus.rvalid_a, bus.rvalid_b}), e.side ? 32'd1 : 32'd2);
                    chk("rdata", 32'(e.side ? bus.rdata_b : bus.rdata_a), 32'(e.data));
                    chk("rvalid_latency", 32'(cyc), 32'(e.cyc + 1));
                end
            end else if (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
                e = sb.pop_front();
                chk("rvalid_missing", 32'({bus.rvalid_a, bus.rvalid_b}), e.side ? 32'd1 : 32'd2);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit r, input bit we, input logic [ADDR_W-1:0] a, input bit d);
        bus.req_a = r; bus.we_a = we; bus.addr_a = a; bus.di_a = d;
    endtask

    task automatic set_b(input bit r, input bit we, input logic [ADDR_W-1:0] a, input bit d);
        bus.req_b = r; bus.we_b = we; bus.addr_b = a; bus.di_b = d;
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 12'h000;
            1:       return 12'hFFF;
            default: return 12'($urandom_range(2040, 2055));
        endcase
    endfunction

    // A new request is drawn only once the previous one was granted or absent
    task automatic rand_reqs();
        if (done_a || !bus.req_a)
            set_a($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)));
        if (done_b || !bus.req_b)
            set_b($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)));
    endtask

    task automatic clear_loop(input int restart_at);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (i == restart_at) clr_start = 1'b1;
            step();
            clr_start = 1'b0;
        end
    endtask

    initial begin
        set_a(1'b1, 1'b1, 12'h000, 1'b1);
        set_b(1'b0, 1'b0, 12'h000, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;

        // Contention straight out of reset alternates A,B,A,B
        set_a(1'b1, 1'b0, 12'h001, 1'b0);
        set_b(1'b1, 1'b0, 12'h002, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_sequence", 32'(last_gnt), (i % 2 == 0) ? 32'd2 : 32'd1);
        end

        // Write by A then read of the same address by B on the next cycle
        set_a(1'b1, 1'b1, 12'h7FF, 1'b1); set_b(1'b0, 1'b0, 12'h000, 1'b0);
        step();
        set_a(1'b0, 1'b0, 12'h000, 1'b0); set_b(1'b1, 1'b0, 12'h7FF, 1'b0);
        step();
        set_b(1'b0, 1'b0, 12'h000, 1'b0);
        step(); step();

        for (int i = 0; i < 400; i++) begin
            rand_reqs();
            step();
        end

        // Full clear; B reads in the start cycle, A holds a read across the clear
        set_b(1'b0, 1'b0, 12'h000, 1'b0);
        set_a(1'b1, 1'b1, 12'h000, 1'b1); step();
        set_a(1'b1, 1'b1, 12'hFFF, 1'b1); step();
        set_a(1'b0, 1'b0, 12'h000, 1'b0);
        set_b(1'b1, 1'b0, 12'hFFF, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        set_b(1'b0, 1'b0, 12'h000, 1'b0);
        set_a(1'b1, 1'b0, 12'h000, 1'b0);
        clear_loop(-1);
        chk("clear_length", 32'(busy_cnt), 32'(DEPTH));
        chk("clear_done_count", 32'(done_cnt), 32'd1);
        set_a(1'b0, 1'b0, 12'h000, 1'b0);
        set_b(1'b1, 1'b0, 12'hFFF, 1'b0);
        step();
        set_b(1'b0, 1'b0, 12'h000, 1'b0);
        step(); step();

        // Restart attempt in the middle of a clear is ignored
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        clear_loop(100);
        chk("restart_clear_length", 32'(busy_cnt), 32'(DEPTH));
        chk("restart_done_count", 32'(done_cnt), 32'd1);

        // Reset in the middle of a clear aborts it without a done pulse
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 2000; i++) step();
        rst_n = 1'b0;
        set_b(1'b1, 1'b0, 12'h0FF, 1'b0);
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();
        chk("gnt_b_after_reset", 32'(last_gnt), 32'd1);
        set_b(1'b0, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("aborted_clear_length", 32'(busy_cnt), 32'd2000);
        chk("aborted_done_count", 32'(done_cnt), 32'd0);

        for (int i = 0; i < 300; i++) begin
            rand_reqs();
            step();
        end
        set_a(1'b0, 1'b0, 12'h000, 1'b0);
        set_b(1'b0, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
